// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store initiator for a word-wide
// synchronous single-port RAM. Sub-word stores are done as read-modify-write
// because the RAM has no byte enables.
module mem_access_unit #(
  parameter int DEPTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [DEPTH+1:0] req_addr,
  input  logic [31:0]      req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_rdata,
  output logic             resp_err,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state;
  state_t      next_state;

  logic        lat_store;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_off;
  logic [15:0] lat_wdata;

  logic        req_err;
  logic        accept;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign accept = (state == IDLE) && req_valid;

  // Flag illegal sizes and misaligned half/word addresses at request time
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = req_addr[0];
      SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
      default:   req_err = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake/write-enable decode, all derived from state
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            next_state = RESP;
          end else if (req_store && (req_size == SIZE_WORD)) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        next_state = CAPTURE;
      end
      CAPTURE: begin
        next_state = lat_store ? WRITE : RESP;
      end
      WRITE: begin
        mem_we     = 1'b1;
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Pick the addressed byte and halfword lanes out of the captured read word
  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (lat_off)
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Sign- or zero-extend the selected lane into the load result
  always_comb begin
    load_data = mem_rdata;
    case (lat_size)
      SIZE_BYTE: load_data = {{24{~lat_unsigned & lane_byte[7]}}, lane_byte};
      SIZE_HALF: load_data = {{16{~lat_unsigned & lane_half[15]}}, lane_half};
      default:   load_data = mem_rdata;
    endcase
  end

  // Splice the store data into its lane, keeping the other lanes of the old word
  always_comb begin
    merged = mem_rdata;
    if (lat_size == SIZE_BYTE) begin
      case (lat_off)
        2'd0:    merged[7:0]   = lat_wdata[7:0];
        2'd1:    merged[15:8]  = lat_wdata[7:0];
        2'd2:    merged[23:16] = lat_wdata[7:0];
        default: merged[31:24] = lat_wdata[7:0];
      endcase
    end else if (lat_off[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end
  end

  // Latch the request on acceptance and register RAM address, write data and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_store    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_off      <= 2'b00;
      lat_wdata    <= 16'h0000;
      mem_addr     <= '0;
      mem_wdata    <= 32'h0000_0000;
      resp_rdata   <= 32'h0000_0000;
      resp_err     <= 1'b0;
    end else if (accept) begin
      lat_store    <= req_store;
      lat_size     <= req_size;
      lat_unsigned <= req_unsigned;
      lat_off      <= req_addr[1:0];
      lat_wdata    <= req_wdata[15:0];
      mem_addr     <= req_addr[DEPTH+1:2];
      resp_rdata   <= 32'h0000_0000;
      resp_err     <= req_err;
      if (req_store && (req_size == SIZE_WORD) && !req_err) begin
        mem_wdata <= req_wdata;
      end
    end else if (state == CAPTURE) begin
      if (lat_store) begin
        mem_wdata <= merged;
      end else begin
        resp_rdata <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store sequences against a behavioural
// synchronous RAM, with hand-computed expected data, latency and write pulses.
module tb_mem_access_unit;

  localparam int DEPTH = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [1:0]       req_size;
  logic             req_unsigned;
  logic [DEPTH+1:0] req_addr;
  logic [31:0]      req_wdata;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic             mem_we;
  logic [DEPTH-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;

  logic [31:0] ram [0:(1<<DEPTH)-1];

  int checks_total  = 0;
  int checks_passed = 0;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Word-wide RAM with one-cycle registered read, read-before-write
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_total++;
    if (actual === expected) begin
      checks_passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request, measure latency and write pulses, optionally stall the response
  task automatic applyStimulus(input string tag, input logic store, input logic [1:0] size,
                               input logic uns, input logic [11:0] addr,
                               input logic [31:0] wdata, input int hold,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int exp_lat, input int exp_we,
                               input logic [9:0] exp_we_addr);
    int         lat;
    int         we_cnt;
    logic [9:0] we_addr;
    bit         seen;
    @(negedge clk);
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid    = 1'b1;
    req_store    = store;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    resp_ready   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'h5A5A_5A5A;
    req_addr  = 12'hFFF;
    lat     = 0;
    we_cnt  = 0;
    we_addr = '0;
    seen    = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
      end
      if (resp_valid) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_rdata"}, resp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
    checkOutput({tag, "_we_pulses"}, we_cnt, exp_we);
    if (exp_we > 0) checkOutput({tag, "_we_addr"}, {22'd0, we_addr}, {22'd0, exp_we_addr});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      checkOutput({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
      checkOutput({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
    checkOutput({tag, "_idle_valid"}, {31'd0, resp_valid}, 32'd0);
  endtask

  // Directed test sequence
  initial begin
    bit seen_we;
    for (int i = 0; i < (1 << DEPTH); i++) ram[i] = 32'h0;
    rst_n        = 1'b1;
    req_valid    = 1'b0;
    req_store    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;
    #3 rst_n = 1'b0;
    #10;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rst_resp_err", {31'd0, resp_err}, 32'd0);
    checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store then word load
    applyStimulus("sw_010", 1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, 32'h0, 0, 2, 1, 10'd4);
    applyStimulus("lw_010", 0, 2'b10, 0, 12'h010, 32'h0, 0, 32'hDEADBEEF, 0, 3, 0, 10'd0);

    // Byte read-modify-write and sign/zero extension
    applyStimulus("sw_seed", 1, 2'b10, 0, 12'h010, 32'h11223344, 0, 32'h0, 0, 2, 1, 10'd4);
    applyStimulus("sb_012", 1, 2'b00, 0, 12'h012, 32'hFFFFFFAA, 0, 32'h0, 0, 4, 1, 10'd4);
    checkOutput("ram_word4_sb", ram[4], 32'h11AA3344);
    applyStimulus("lw_after_sb", 0, 2'b10, 0, 12'h010, 32'h0, 0, 32'h11AA3344, 0, 3, 0, 10'd0);
    applyStimulus("lb_012", 0, 2'b00, 0, 12'h012, 32'h0, 0, 32'hFFFFFFAA, 0, 3, 0, 10'd0);
    applyStimulus("lbu_012", 0, 2'b00, 1, 12'h012, 32'h0, 0, 32'h000000AA, 0, 3, 0, 10'd0);
    applyStimulus("lh_012", 0, 2'b01, 0, 12'h012, 32'h0, 0, 32'h000011AA, 0, 3, 0, 10'd0);
    applyStimulus("lb_013", 0, 2'b00, 0, 12'h013, 32'h0, 0, 32'h00000011, 0, 3, 0, 10'd0);
    applyStimulus("lh_010", 0, 2'b01, 0, 12'h010, 32'h0, 0, 32'h00003344, 0, 3, 0, 10'd0);

    // Halfword store into the upper lane, then signed and unsigned loads
    applyStimulus("sh_012", 1, 2'b01, 0, 12'h012, 32'h1234BEEF, 0, 32'h0, 0, 4, 1, 10'd4);
    checkOutput("ram_word4_sh", ram[4], 32'hBEEF3344);
    applyStimulus("lhu_012", 0, 2'b01, 1, 12'h012, 32'h0, 0, 32'h0000BEEF, 0, 3, 0, 10'd0);
    applyStimulus("lh_012s", 0, 2'b01, 0, 12'h012, 32'h0, 0, 32'hFFFFBEEF, 0, 3, 0, 10'd0);

    // Errors: misaligned word/half, illegal size, misaligned store
    applyStimulus("lw_013", 0, 2'b10, 0, 12'h013, 32'h0, 0, 32'h0, 1, 1, 0, 10'd0);
    applyStimulus("lh_011", 0, 2'b01, 0, 12'h011, 32'h0, 0, 32'h0, 1, 1, 0, 10'd0);
    applyStimulus("size_11", 0, 2'b11, 0, 12'h010, 32'h0, 0, 32'h0, 1, 1, 0, 10'd0);
    applyStimulus("sw_012", 1, 2'b10, 0, 12'h012, 32'h0BADF00D, 0, 32'h0, 1, 1, 0, 10'd0);
    checkOutput("ram_word4_err", ram[4], 32'hBEEF3344);

    // Backpressure: response held five cycles
    applyStimulus("lw_stall", 0, 2'b10, 0, 12'h010, 32'h0, 5, 32'hBEEF3344, 0, 3, 0, 10'd0);

    // Top of address space
    applyStimulus("sw_ffc", 1, 2'b10, 0, 12'hFFC, 32'hCAFEF00D, 0, 32'h0, 0, 2, 1, 10'd1023);
    applyStimulus("sb_fff", 1, 2'b00, 0, 12'hFFF, 32'h0000005A, 0, 32'h0, 0, 4, 1, 10'd1023);
    applyStimulus("lw_ffc", 0, 2'b10, 0, 12'hFFC, 32'h0, 0, 32'h5AFEF00D, 0, 3, 0, 10'd0);

    // Reset asserted while the byte store is in WRITE
    @(negedge clk);
    req_valid    = 1'b1;
    req_store    = 1'b1;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 12'h010;
    req_wdata    = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    seen_we   = 1'b0;
    for (int n = 0; n < 10 && !seen_we; n++) begin
      if (n > 0) @(negedge clk);
      if (mem_we) seen_we = 1'b1;
    end
    checkOutput("rmid_we_seen", {31'd0, seen_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rmid_mem_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rmid_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rmid_resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rmid_mem_addr", {22'd0, mem_addr}, 32'd0);
    checkOutput("rmid_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rmid_resp_rdata", resp_rdata, 32'd0);
    checkOutput("rmid_resp_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rmid_ram_word4", ram[4], 32'hBEEF3344);
    applyStimulus("lw_post_rst", 0, 2'b10, 0, 12'h010, 32'h0, 0, 32'hBEEF3344, 0, 3, 0, 10'd0);
    applyStimulus("lbu_post_rst", 0, 2'b00, 1, 12'h013, 32'h0, 0, 32'h000000BE, 0, 3, 0, 10'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
